// File: rtl/rover_move_scheduler.sv
// rover_move_scheduler: queues IR command words and hands them to the motor
// controller one at a time. Between moves there is a fixed idle pause.
//
// Handshake: a new command is taken on the rising edge of the move_ready level.
// A move is launched by a one-cycle start_move strobe with move_data valid in
// the same cycle. The move counts as finished on a rising edge of the
// move_done level.
//
// Optional feature: define MOVE_WATCHDOG_EN to build a per-move watchdog. When
// it is enabled, WAIT is abandoned after TIMEOUT_CYCLES and the sticky
// timeout flag is set.
module rover_move_scheduler #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned GAP_CYCLES     = 25000,
  parameter int unsigned TIMEOUT_CYCLES = 250000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        move_ready,
  input  logic [11:0] move_data_t,
  input  logic        move_done,
  input  logic        flush,
  output logic        start_move,
  output logic [11:0] move_data,
  output logic        busy,
  output logic [4:0]  count,
  output logic        overflow,
  output logic        timeout,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_ISSUE = 4'd1,
    ST_WAIT  = 4'd2,
    ST_GAP   = 4'd3
  } state_t;

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [4:0] DEPTH_CNT = 5'(DEPTH);
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  // Reject parameter sets the pointer arithmetic cannot support.
  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 ||
      GAP_CYCLES == 0 || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("rover_move_scheduler: unsupported parameter set");
  end

  state_t           cur_st;
  state_t           nxt_st;
  logic             ready_q;
  logic             done_q;
  logic [11:0]      mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [4:0]       count_nxt;
  logic [GAP_W-1:0] gap_cnt;
  logic             push_req;
  logic             push_ok;
  logic             push_drop;
  logic             pop_eff;
  logic             done_rise;
  logic             wd_expire;

  // A push is a fresh move_ready rise carrying a non-null word. A flush in
  // the same cycle discards it.
  assign push_req  = move_ready && !ready_q && (move_data_t != 12'h000) && !flush;
  // The head leaves the queue during the ISSUE cycle.
  assign pop_eff   = (cur_st == ST_ISSUE) && (count != 5'd0);
  // A full queue still accepts a push when a pop frees a slot in the same cycle.
  assign push_ok   = push_req && ((count != DEPTH_CNT) || pop_eff);
  assign push_drop = push_req && (count == DEPTH_CNT) && !pop_eff;
  // A move_done level that was already high on WAIT entry is not an edge.
  assign done_rise = move_done && !done_q;
  assign state     = cur_st;

  // Compute the queue occupancy after this cycle.
  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = 5'd0;
    end else begin
      count_nxt = count + 5'(push_ok) - 5'(pop_eff);
    end
  end

  // Sample the input levels for the rising-edge detectors.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ready_q <= move_ready;
      done_q  <= move_done;
    end
  end

  // Command storage has no reset. The pointers alone define which entries are valid.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= move_data_t;
    end
  end

  // Update the queue pointers and occupancy. The pointers wrap at a power-of-two depth.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= 5'd0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= 5'd0;
    end else begin
      if (pop_eff) rd_ptr <= rd_ptr + PTR_ONE;
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      count <= count_nxt;
    end
  end

`ifdef MOVE_WATCHDOG_EN
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);
  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;

  assign wd_expire = (wd_cnt == WD_LAST);
  assign timeout   = timeout_q;

  // Count the cycles spent in WAIT. Flag the move when it runs out of time.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (cur_st == ST_WAIT && !done_rise) begin
        wd_cnt <= wd_cnt + WD_ONE;
        if (wd_expire) timeout_q <= 1'b1;
      end else begin
        wd_cnt <= '0;
      end
    end
  end
`else
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

  // Next-state logic for the move sequencer.
  always_comb begin
    nxt_st = cur_st;
    case (cur_st)
      ST_IDLE:  if (count != 5'd0 && !flush) nxt_st = ST_ISSUE;
      ST_ISSUE: nxt_st = ST_WAIT;
      ST_WAIT:  if (done_rise || wd_expire) nxt_st = ST_GAP;
      ST_GAP:   if (gap_cnt == GAP_LAST) nxt_st = ST_IDLE;
      default:  nxt_st = ST_IDLE;
    endcase
  end

  // Hold the sequencer state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cur_st <= ST_IDLE;
    else       cur_st <= nxt_st;
  end

  // Count the pause cycles while in GAP. The counter restarts from zero on every entry to GAP.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 gap_cnt <= '0;
    else if (cur_st == ST_GAP) gap_cnt <= gap_cnt + GAP_ONE;
    else                       gap_cnt <= '0;
  end

  // Drive the registered outputs.
  // The strobe and data word are loaded on the edge that enters ISSUE, so they appear in the ISSUE cycle itself.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      start_move <= 1'b0;
      move_data  <= 12'h000;
      busy       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      start_move <= (nxt_st == ST_ISSUE) && (cur_st != ST_ISSUE);
      if (nxt_st == ST_ISSUE && cur_st != ST_ISSUE) move_data <= mem[rd_ptr];
      busy <= (nxt_st != ST_IDLE) || (count_nxt != 5'd0);
      if (push_drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rover_move_scheduler.sv
// tb_rover_move_scheduler: self-checking bench for rover_move_scheduler.
// A behavioural reference (a command queue plus a phase/countdown description
// of the move sequence) runs in lockstep. Every cycle the DUT outputs are
// compared against it. Directed scenarios add checks against hand-derived constants.
module tb_rover_move_scheduler;

  localparam int DEPTH = 4;
  localparam int GAP   = 16;
  localparam int TO    = 1000;

  localparam int PH_IDLE  = 0;
  localparam int PH_ISSUE = 1;
  localparam int PH_WAIT  = 2;
  localparam int PH_GAP   = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        move_ready;
  logic [11:0] move_data_t;
  logic        move_done;
  logic        flush;
  logic        start_move;
  logic [11:0] move_data;
  logic        busy;
  logic [4:0]  count;
  logic        overflow;
  logic        timeout;
  logic [3:0]  state;

  rover_move_scheduler #(
    .DEPTH(DEPTH),
    .GAP_CYCLES(GAP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .move_ready(move_ready),
    .move_data_t(move_data_t),
    .move_done(move_done),
    .flush(flush),
    .start_move(start_move),
    .move_data(move_data),
    .busy(busy),
    .count(count),
    .overflow(overflow),
    .timeout(timeout),
    .state(state)
  );

  // ---------------- clock / reset ----------------
  always #20 clock = ~clock;

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_starts = 0;
  logic [11:0] got_issues[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [11:0] exp_q[$];
  int          m_phase      = PH_IDLE;
  int          m_gap_left   = 0;
  int          m_wait_len   = 0;
  bit          m_ready_prev = 0;
  bit          m_done_prev  = 0;
  bit          m_start      = 0;
  bit          m_over       = 0;
  bit          m_tmo        = 0;
  logic [11:0] m_data       = 12'h000;

  task automatic model_reset();
    exp_q.delete();
    m_phase = PH_IDLE; m_gap_left = 0; m_wait_len = 0;
    m_ready_prev = 0; m_done_prev = 0;
    m_start = 0; m_over = 0; m_tmo = 0; m_data = 12'h000;
  endtask

  task automatic model_step();
    bit rise;
    bit drise;
    int nph;
    rise  = move_ready && !m_ready_prev;
    drise = move_done && !m_done_prev;
    nph   = m_phase;
    m_start = 0;
    case (m_phase)
      PH_IDLE: if (exp_q.size() > 0 && !flush) begin
        nph = PH_ISSUE; m_start = 1; m_data = exp_q[0];
      end
      PH_ISSUE: begin nph = PH_WAIT; m_wait_len = 0; end
      PH_WAIT: if (drise) begin
        nph = PH_GAP; m_gap_left = GAP;
      end else begin
        m_wait_len++;
`ifdef MOVE_WATCHDOG_EN
        if (m_wait_len == TO) begin nph = PH_GAP; m_gap_left = GAP; m_tmo = 1; end
`endif
      end
      default: begin
        m_gap_left--;
        if (m_gap_left == 0) nph = PH_IDLE;
      end
    endcase
    if (flush) exp_q.delete();
    else begin
      if (m_phase == PH_ISSUE && exp_q.size() > 0) void'(exp_q.pop_front());
      if (rise && move_data_t != 12'h000) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(move_data_t);
        else m_over = 1;
      end
    end
    m_phase = nph;
    m_ready_prev = move_ready;
    m_done_prev  = move_done;
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) model_reset();
    else       model_step();
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clock);
    check_val("state", state, m_phase);
    check_val("count", count, exp_q.size());
    check_val("start_move", start_move, m_start);
    check_val("move_data", move_data, m_data);
    check_val("busy", busy, (m_phase != PH_IDLE) || (exp_q.size() > 0));
    check_val("overflow", overflow, m_over);
    check_val("timeout", timeout, m_tmo);
    if (start_move === 1'b1) begin
      n_starts++;
      got_issues.push_back(move_data);
    end
  endtask

  task automatic push_cmd(input logic [11:0] d);
    move_ready = 1'b1; move_data_t = d; step();
    move_ready = 1'b0; step();
  endtask

  task automatic wait_phase(input int ph, input int limit);
    int n = 0;
    while (state != 4'(ph) && n < limit) begin step(); n++; end
    check_val("wait_phase", state, ph);
  endtask

  task automatic finish_move();
    wait_phase(PH_WAIT, 200);
    move_done = 1'b1; step();
    move_done = 1'b0; step();
  endtask

  task automatic drain();
    int n = 0;
    move_ready = 1'b0; move_done = 1'b0; flush = 1'b1; step();
    flush = 1'b0;
    while (state != 4'd0 && n < 400) begin
      move_done = (state == 4'd2) && !move_done;
      step(); n++;
    end
    move_done = 1'b0; step();
    check_val("drain_idle", state, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int gap_len;
    int s0;
    $display("config: DEPTH=%0d GAP=%0d TIMEOUT=%0d", DEPTH, GAP, TO);
    reset = 1'b1; move_ready = 1'b0; move_done = 1'b0; flush = 1'b0; move_data_t = 12'h000;
    step(); step();
    check_val("rst_state", state, 0);
    check_val("rst_count", count, 0);
    check_val("rst_data", move_data, 12'h000);
    reset = 1'b0;
    step(); step();

    // Single move: issue two cycles after the push, then a GAP of exactly GAP cycles.
    move_ready = 1'b1; move_data_t = 12'h0A5; step();
    check_val("lat_c1_start", start_move, 0);
    move_ready = 1'b0; step();
    check_val("lat_c2_start", start_move, 1);
    check_val("lat_c2_data", move_data, 12'h0A5);
    step();
    move_done = 1'b1; step(); move_done = 1'b0;
    gap_len = 0;
    while (state == 4'd3 && gap_len < GAP + 10) begin gap_len++; step(); end
    check_val("gap_len", gap_len, GAP);
    check_val("idle_busy", busy, 0);
    check_val("hold_data", move_data, 12'h0A5);

    // Held level: one push only; a done level held through ISSUE does not complete the move.
    s0 = n_starts;
    move_ready = 1'b1; move_data_t = 12'h321;
    for (int i = 0; i < 100; i++) step();
    move_ready = 1'b0; step();
    check_val("held_one_push", n_starts - s0, 1);
    wait_phase(PH_WAIT, 50);
    move_done = 1'b1; step();
    push_cmd(12'h654);
    wait_phase(PH_WAIT, 100);
    for (int i = 0; i < 20; i++) step();
    check_val("held_done_wait", state, 2);
    move_done = 1'b0; step();
    finish_move();
    wait_phase(PH_IDLE, 100);

    // Flush: three are queued while a move is in WAIT. The current move finishes and nothing else issues.
    push_cmd(12'h111); push_cmd(12'h222); push_cmd(12'h333); push_cmd(12'h444);
    check_val("flush_pre_count", count, 3);
    check_val("flush_pre_state", state, 2);
    flush = 1'b1; step(); flush = 1'b0;
    check_val("flush_count", count, 0);
    s0 = n_starts;
    finish_move();
    for (int i = 0; i < GAP + 20; i++) step();
    check_val("flush_no_start", n_starts - s0, 0);
    check_val("flush_busy", busy, 0);

    // Burst with the motor stalled: five pushes are accepted and the sixth overflows.
    got_issues.delete();
    for (int i = 1; i <= 6; i++) push_cmd(12'(i));
    check_val("burst_count", count, 4);
    check_val("burst_overflow", overflow, 1);
    for (int i = 0; i < 5; i++) finish_move();
    wait_phase(PH_IDLE, 100);
    check_val("burst_issues", got_issues.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < got_issues.size()) check_val("burst_order", got_issues[i], 12'(i + 1));
    end

    // Randomized traffic. The model checks every cycle.
    for (int i = 0; i < 2500; i++) begin
      move_ready  = ($urandom_range(0, 2) == 0);
      move_data_t = ($urandom_range(0, 7) == 0) ? 12'h000 : 12'($urandom_range(1, 4095));
      move_done   = ($urandom_range(0, 3) == 0);
      flush       = ($urandom_range(0, 149) == 0);
      step();
    end
    drain();

    // The motor never reports done.
    push_cmd(12'h7AA); push_cmd(12'h7BB);
    for (int i = 0; i < 1100; i++) step();
`ifdef MOVE_WATCHDOG_EN
    check_val("wd_timeout", timeout, 1);
    check_val("wd_next_data", move_data, 12'h7BB);
    check_val("wd_count", count, 0);
`else
    check_val("nowd_timeout", timeout, 0);
    check_val("nowd_data", move_data, 12'h7AA);
    check_val("nowd_count", count, 1);
`endif
    check_val("wd_state", state, 2);
    drain();

    // Reset asserted in WAIT with two commands queued.
    push_cmd(12'h0C1); push_cmd(12'h0C2); push_cmd(12'h0C3);
    check_val("rw_count", count, 2);
    check_val("rw_state", state, 2);
    reset = 1'b1; step();
    check_val("rw_rst_state", state, 0);
    check_val("rw_rst_count", count, 0);
    check_val("rw_rst_start", start_move, 0);
    check_val("rw_rst_data", move_data, 12'h000);
    check_val("rw_rst_busy", busy, 0);
    check_val("rw_rst_over", overflow, 0);
    check_val("rw_rst_tmo", timeout, 0);
    step();
    reset = 1'b0;
    s0 = n_starts;
    for (int i = 0; i < 60; i++) step();
    check_val("rw_no_start", n_starts - s0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
